// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS memory bus: arbiter FSM states,
// grant-source identifiers and default bus widths.
package mips_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Byte-enable pattern used for instruction fetches (full word).
    localparam logic [3:0] FETCH_BE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_IF = 2'd1,
        ST_GNT_D  = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } grant_src_e;

    // Round-robin pick when both requesters are pending: the side that
    // was not served last wins.
    function automatic grant_src_e rr_pick(input grant_src_e last_grant);
        return (last_grant == SRC_IF) ? SRC_D : SRC_IF;
    endfunction

endpackage

// File: rtl/arb_wdog.sv
// Watchdog for a single memory access: counts stalled cycles and flags
// expiry in the cycle the count reaches LIMIT.
module arb_wdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_reg;

    // Stall counter: cleared while idle, advanced on every stalled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Expiry fires in the stalled cycle that brings the count up to LIMIT.
    always_comb begin
        expire = inc && (cnt_reg == CNT_W'(LIMIT - 1));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the
// instruction-fetch path and the data path of the MIPS core.
// Optional watchdog: define ARB_TIMEOUT_EN to abort accesses stalled
// for TIMEOUT_CYCLES cycles (acks with zero data and sets sticky err).
module mem_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    arb_state_e        state_reg;
    grant_src_e        last_grant_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [3:0]        be_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              err_reg;
    logic              granted;
    logic              expire;
    logic              done;

    // A zero-length watchdog would abort every access immediately.
    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    assign granted = (state_reg != ST_IDLE);

`ifdef ARB_TIMEOUT_EN
    arb_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (!granted),
        .inc    (granted && !mem_ready),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // An access ends on memory completion or on watchdog expiry.
    assign done = granted && (mem_ready || expire);

    // Arbitration FSM: grant from IDLE, latch the winner's request, wait
    // for completion, then return to IDLE (one bubble between accesses).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= SRC_IF;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            be_reg         <= '0;
            wdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (d_req && (!if_req || rr_pick(last_grant_reg) == SRC_D)) begin
                        state_reg <= ST_GNT_D;
                        addr_reg  <= d_addr;
                        we_reg    <= d_we;
                        be_reg    <= d_be;
                        wdata_reg <= d_wdata;
                    end else if (if_req) begin
                        state_reg <= ST_GNT_IF;
                        addr_reg  <= if_addr;
                        we_reg    <= 1'b0;
                        be_reg    <= FETCH_BE;
                        wdata_reg <= '0;
                    end
                end
                ST_GNT_IF, ST_GNT_D: begin
                    if (done) begin
                        state_reg      <= ST_IDLE;
                        last_grant_reg <= (state_reg == ST_GNT_D) ? SRC_D : SRC_IF;
                        // Only a genuine stall-out is an error; a late
                        // mem_ready in the expiry cycle still wins.
                        if (!mem_ready) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs: driven from the latched request while granted.
    always_comb begin
        mem_ce    = granted;
        mem_we    = granted ? we_reg    : 1'b0;
        mem_be    = granted ? be_reg    : 4'h0;
        mem_addr  = granted ? addr_reg  : '0;
        mem_wdata = granted ? wdata_reg : '0;
    end

    // Requester-side completion: ack and data only in the finishing cycle;
    // an aborted access returns zero data.
    always_comb begin
        if_ack   = done && (state_reg == ST_GNT_IF);
        d_ack    = done && (state_reg == ST_GNT_D);
        if_rdata = (if_ack && mem_ready) ? mem_rdata : '0;
        d_rdata  = (d_ack  && mem_ready) ? mem_rdata : '0;
        err      = err_reg;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch with wait states, data write,
// round-robin contention, reset mid-access and stalled-memory behaviour.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One comparison, checked 1 ns after inputs settle.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int acks_seen;
        bit exp_d;

        rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_ce", 32'(mem_ce), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;
        cyc();

        // Fetch with two wait cycles: cycle N
        if_req = 1; if_addr = 32'h0000_0040; mem_rdata = 32'h2408_0005; #1;
        $display("txn fetch addr=%h", if_addr);
        chk("f_N_ce", 32'(mem_ce), 32'd0);
        cyc(); #1;                                   // N+1
        chk("f_N1_ce", 32'(mem_ce), 32'd1);
        chk("f_N1_we", 32'(mem_we), 32'd0);
        chk("f_N1_be", 32'(mem_be), 32'hF);
        chk("f_N1_addr", mem_addr, 32'h40);
        chk("f_N1_ack", 32'(if_ack), 32'd0);
        cyc(); #1;                                   // N+2
        chk("f_N2_ce", 32'(mem_ce), 32'd1);
        chk("f_N2_ack", 32'(if_ack), 32'd0);
        cyc(); mem_ready = 1; #1;                    // N+3
        chk("f_N3_ack", 32'(if_ack), 32'd1);
        chk("f_N3_rdata", if_rdata, 32'h2408_0005);
        chk("f_N3_dack", 32'(d_ack), 32'd0);
        cyc(); if_req = 0; #1;                       // N+4, ready still high in IDLE
        chk("f_N4_ce", 32'(mem_ce), 32'd0);
        chk("idle_ready_ack", 32'(if_ack), 32'd0);
        chk("idle_rdata", if_rdata, 32'd0);
        mem_ready = 0;
        cyc();

        // Data write completing in the same cycle as ce
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        mem_rdata = 32'h1234_5678;
        $display("txn write addr=%h data=%h", d_addr, d_wdata);
        cyc(); mem_ready = 1; #1;
        chk("w_ce", 32'(mem_ce), 32'd1);
        chk("w_we", 32'(mem_we), 32'd1);
        chk("w_be", 32'(mem_be), 32'b0011);
        chk("w_addr", mem_addr, 32'h100);
        chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("w_dack", 32'(d_ack), 32'd1);
        chk("w_ifack", 32'(if_ack), 32'd0);
        chk("w_drdata", d_rdata, 32'h1234_5678);
        cyc(); d_req = 0; d_we = 0; mem_ready = 0; #1;
        chk("w_after_ce", 32'(mem_ce), 32'd0);

        // Contention from reset: D, IF, D, IF with one idle cycle between
        rst = 1; cyc(); rst = 0;
        if_req = 1; if_addr = 32'h80; d_req = 1; d_addr = 32'h200; d_we = 0; d_be = 4'hF;
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D; #1;
        chk("rr_N_ce", 32'(mem_ce), 32'd0);
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            cyc(); #1;
            $display("txn contention grant %0d expect %s", k, exp_d ? "D" : "IF");
            chk("rr_ce", 32'(mem_ce), 32'd1);
            chk("rr_addr", mem_addr, exp_d ? 32'h200 : 32'h80);
            chk("rr_dack", 32'(d_ack), 32'(exp_d));
            chk("rr_ifack", 32'(if_ack), 32'(!exp_d));
            cyc(); #1;
            chk("rr_gap_ce", 32'(mem_ce), 32'd0);
            chk("rr_gap_acks", 32'({if_ack, d_ack}), 32'd0);
        end
        // Still in the gap cycle: drop both before the next edge
        if_req = 0; d_req = 0; mem_ready = 0;
        cyc(); #1;
        chk("rr_end_ce", 32'(mem_ce), 32'd0);

        // Reset while GNT_IF stalls
        if_req = 1; if_addr = 32'hC0; mem_rdata = 32'h0000_00C0;
        $display("txn fetch with reset mid-access addr=%h", if_addr);
        cyc(); #1;
        chk("rm_ce", 32'(mem_ce), 32'd1);
        rst = 1;
        cyc(); mem_ready = 1; #1;
        chk("rm_ce_rst", 32'(mem_ce), 32'd0);
        chk("rm_acks_rst", 32'({if_ack, d_ack}), 32'd0);
        rst = 0;
        cyc(); #1;
        chk("rm_retry_ce", 32'(mem_ce), 32'd1);
        chk("rm_retry_ack", 32'(if_ack), 32'd1);
        chk("rm_retry_rdata", if_rdata, 32'h0000_00C0);
        cyc(); if_req = 0; mem_ready = 0; #1;
        chk("rm_done_ce", 32'(mem_ce), 32'd0);

        // Stalled memory on a data read
        d_req = 1; d_we = 0; d_addr = 32'h300; mem_rdata = 32'hFFFF_FFFF; mem_ready = 0;
        $display("txn stalled read addr=%h", d_addr);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            cyc(); #1;
            chk("to_wait_ack", 32'(d_ack), 32'd0);
        end
        cyc(); #1;                                   // 4th GNT_D cycle
        chk("to_ack", 32'(d_ack), 32'd1);
        chk("to_rdata", d_rdata, 32'd0);
        cyc(); d_req = 0; #1;
        chk("to_ce", 32'(mem_ce), 32'd0);
        chk("to_err", 32'(err), 32'd1);
        repeat (5) cyc();
        #1;
        chk("to_err_sticky", 32'(err), 32'd1);
        rst = 1; cyc(); rst = 0; #1;
        chk("to_err_cleared", 32'(err), 32'd0);
`else
        acks_seen = 0;
        repeat (1000) begin
            cyc(); #1;
            if (d_ack || if_ack || err) acks_seen++;
        end
        chk("hang_no_ack", 32'(acks_seen), 32'd0);
        chk("hang_ce", 32'(mem_ce), 32'd1);
        chk("hang_err", 32'(err), 32'd0);
        d_req = 0;
        rst = 1; cyc(); rst = 0; #1;
        chk("hang_rst_ce", 32'(mem_ce), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
